// File: rtl/io_burst_reader_pkg.sv
// Shared types and helpers for the slave_clk-domain burst reader that feeds the
// I/O clock-crossing bridge.
package io_burst_reader_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DRAIN = 2'd2,
        FIN   = 2'd3
    } state_t;

    localparam logic [3:0] BYTEENABLE_ALL = 4'hF;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 30; i++) begin
            if ((32'sd1 <<< i) < value) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/io_burst_reader_fifo.sv
// Show-ahead return-data buffer: the head entry is visible on pop_data while
// the buffer is non-empty; writes land one cycle after push.
module io_burst_reader_fifo
    import io_burst_reader_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int WIDTH = 33,
    localparam int CW = clog2(DEPTH) + 1
) (
    input  logic             slave_clk,
    input  logic             slave_reset_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic [CW-1:0]    count,
    output logic             empty,
    output logic             full
);

    localparam int AW = CW - 1;
    localparam logic [CW-1:0] FULL_LEVEL = CW'(DEPTH);

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [AW-1:0]    wr_ptr_r;
    logic [AW-1:0]    rd_ptr_r;
    logic [CW-1:0]    count_r;
    logic             wr_en_s;
    logic             rd_en_s;

    assign empty    = (count_r == {CW{1'b0}});
    assign full     = (count_r == FULL_LEVEL);
    assign count    = count_r;
    assign wr_en_s  = push & ~full;
    assign rd_en_s  = pop & ~empty;
    assign pop_data = mem_r[rd_ptr_r];

    // Storage array, written at the tail pointer
    always_ff @(posedge slave_clk) begin
        if (wr_en_s) begin
            mem_r[wr_ptr_r] <= push_data;
        end
    end

    // Pointers and occupancy; simultaneous push and pop keep the count
    always_ff @(posedge slave_clk or negedge slave_reset_n) begin
        if (!slave_reset_n) begin
            wr_ptr_r <= {AW{1'b0}};
            rd_ptr_r <= {AW{1'b0}};
            count_r  <= {CW{1'b0}};
        end else begin
            if (wr_en_s) begin
                wr_ptr_r <= wr_ptr_r + AW'(1);
            end
            if (rd_en_s) begin
                rd_ptr_r <= rd_ptr_r + AW'(1);
            end
            case ({wr_en_s, rd_en_s})
                2'b10:   count_r <= count_r + CW'(1);
                2'b01:   count_r <= count_r - CW'(1);
                default: count_r <= count_r;
            endcase
        end
    end

endmodule

// File: rtl/io_burst_reader.sv
// Avalon-MM read-burst master for the bridge s1 port; outstanding reads are
// bounded by buffer space because bridge returns cannot be stalled.
module io_burst_reader
    import io_burst_reader_pkg::*;
#(
    parameter int FIFO_DEPTH = 16,
    parameter int ADDR_W     = 9,
    parameter int CNT_W      = 10
) (
    input  logic              slave_clk,
    input  logic              slave_reset_n,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [ADDR_W-1:0] cmd_address,
    input  logic [CNT_W-1:0]  cmd_count,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] avm_address,
    output logic [ADDR_W-1:0] avm_nativeaddress,
    output logic [3:0]        avm_byteenable,
    output logic              avm_read,
    output logic              avm_write,
    output logic [31:0]       avm_writedata,
    input  logic              avm_waitrequest,
    input  logic [31:0]       avm_readdata,
    input  logic              avm_readdatavalid,
    input  logic              avm_endofpacket,
    output logic [31:0]       out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              out_last,
    output logic              err_unexpected
);

    localparam int PW = clog2(FIFO_DEPTH) + 1;
    localparam int SW = PW + 1;
    localparam logic [SW-1:0] CREDIT_LIMIT = SW'(FIFO_DEPTH);

    state_t            state_r, state_s;
    logic [ADDR_W-1:0] addr_r;
    logic [CNT_W-1:0]  count_r, count_s;
    logic [CNT_W-1:0]  issued_r, issued_s;
    logic [CNT_W-1:0]  ret_idx_r;
    logic [PW-1:0]     pending_r;
    logic [PW-1:0]     fifo_count_s;
    logic [SW-1:0]     credit_use_s;
    logic              read_r, read_s;
    logic              err_r;
    logic              cmd_take_s, accept_s, push_s, pop_s, last_pop_s;
    logic              fifo_empty_s, fifo_full_s;
    logic [32:0]       fifo_dout_s;

    assign cmd_take_s = cmd_valid & (state_r == IDLE);
    assign accept_s   = read_r & ~avm_waitrequest;
    assign push_s     = avm_readdatavalid & (pending_r != {PW{1'b0}}) & ~fifo_full_s;
    assign pop_s      = ~fifo_empty_s & out_ready;
    assign last_pop_s = pop_s & fifo_dout_s[32];
    // Reads in flight plus buffered words, as they will stand after this edge
    assign credit_use_s = SW'(pending_r) + SW'(fifo_count_s) + SW'(accept_s) - SW'(pop_s);

    // Next-state, command capture and issue counting
    always_comb begin
        state_s  = state_r;
        count_s  = count_r;
        issued_s = issued_r;
        case (state_r)
            IDLE: begin
                if (cmd_take_s) begin
                    count_s  = cmd_count;
                    issued_s = {CNT_W{1'b0}};
                    state_s  = (cmd_count == {CNT_W{1'b0}}) ? FIN : ISSUE;
                end else begin
                    state_s = IDLE;
                end
            end
            ISSUE: begin
                if (accept_s) begin
                    issued_s = issued_r + CNT_W'(1);
                    state_s  = (issued_s == count_r) ? DRAIN : ISSUE;
                end else begin
                    state_s = ISSUE;
                end
            end
            DRAIN: begin
                if (last_pop_s) begin
                    state_s = FIN;
                end else begin
                    state_s = DRAIN;
                end
            end
            FIN:     state_s = IDLE;
            default: state_s = IDLE;
        endcase
        read_s = (state_s == ISSUE) && (issued_s != count_s) && (credit_use_s < CREDIT_LIMIT);
    end

    // Control state, request and address registers
    always_ff @(posedge slave_clk or negedge slave_reset_n) begin
        if (!slave_reset_n) begin
            state_r  <= IDLE;
            count_r  <= {CNT_W{1'b0}};
            issued_r <= {CNT_W{1'b0}};
            read_r   <= 1'b0;
            addr_r   <= {ADDR_W{1'b0}};
        end else begin
            state_r  <= state_s;
            count_r  <= count_s;
            issued_r <= issued_s;
            read_r   <= read_s;
            if (cmd_take_s) begin
                addr_r <= cmd_address;
            end else if (accept_s) begin
                addr_r <= addr_r + ADDR_W'(1);
            end
        end
    end

    // Return-side bookkeeping: outstanding reads, return index, stray strobes
    always_ff @(posedge slave_clk or negedge slave_reset_n) begin
        if (!slave_reset_n) begin
            pending_r <= {PW{1'b0}};
            ret_idx_r <= {CNT_W{1'b0}};
            err_r     <= 1'b0;
        end else begin
            pending_r <= pending_r + PW'(accept_s) - PW'(push_s);
            if (cmd_take_s) begin
                ret_idx_r <= {CNT_W{1'b0}};
            end else if (push_s) begin
                ret_idx_r <= ret_idx_r + CNT_W'(1);
            end
            err_r <= err_r | (avm_readdatavalid & (pending_r == {PW{1'b0}}));
        end
    end

    io_burst_reader_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (33)
    ) u_fifo (
        .slave_clk     (slave_clk),
        .slave_reset_n (slave_reset_n),
        .push          (push_s),
        .push_data     ({(ret_idx_r == count_r - CNT_W'(1)), avm_readdata}),
        .pop           (pop_s),
        .pop_data      (fifo_dout_s),
        .count         (fifo_count_s),
        .empty         (fifo_empty_s),
        .full          (fifo_full_s)
    );

    assign cmd_ready         = (state_r == IDLE);
    assign busy              = (state_r != IDLE);
    assign done              = (state_r == FIN);
    assign avm_address       = addr_r;
    assign avm_nativeaddress = addr_r;
    assign avm_byteenable    = BYTEENABLE_ALL;
    assign avm_read          = read_r;
    assign avm_write         = 1'b0;
    assign avm_writedata     = 32'h0000_0000;
    assign out_data          = fifo_dout_s[31:0];
    assign out_valid         = ~fifo_empty_s;
    assign out_last          = fifo_dout_s[32] & ~fifo_empty_s;
    assign err_unexpected    = err_r;

endmodule

// File: tb/tb_io_burst_reader.sv
// Directed bench for io_burst_reader with a fixed-latency bridge model that
// returns rd_data(address) two cycles after each accepted read.
module tb_io_burst_reader;

    logic        slave_clk, slave_reset_n;
    logic        cmd_valid, cmd_ready;
    logic [8:0]  cmd_address;
    logic [9:0]  cmd_count;
    logic        busy, done;
    logic [8:0]  avm_address, avm_nativeaddress;
    logic [3:0]  avm_byteenable;
    logic        avm_read, avm_write;
    logic [31:0] avm_writedata;
    logic        avm_waitrequest;
    logic [31:0] avm_readdata;
    logic        avm_readdatavalid, avm_endofpacket;
    logic [31:0] out_data;
    logic        out_valid, out_ready, out_last, err_unexpected;

    logic        rsp_valid, stray_valid;
    logic [31:0] rsp_data;
    int          n_checks = 0;
    int          n_fail = 0;

    assign avm_readdatavalid = rsp_valid | stray_valid;
    assign avm_readdata      = stray_valid ? 32'hDEAD_0BAD : rsp_data;

    io_burst_reader dut (
        .slave_clk(slave_clk), .slave_reset_n(slave_reset_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_address(cmd_address), .cmd_count(cmd_count),
        .busy(busy), .done(done),
        .avm_address(avm_address), .avm_nativeaddress(avm_nativeaddress),
        .avm_byteenable(avm_byteenable), .avm_read(avm_read),
        .avm_write(avm_write), .avm_writedata(avm_writedata),
        .avm_waitrequest(avm_waitrequest), .avm_readdata(avm_readdata),
        .avm_readdatavalid(avm_readdatavalid), .avm_endofpacket(avm_endofpacket),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .out_last(out_last), .err_unexpected(err_unexpected)
    );

    initial begin
        slave_clk = 1'b0;
        forever #5 slave_clk = ~slave_clk;
    end

    function automatic logic [31:0] rd_data(input logic [8:0] a);
        return {16'hBEEF, 7'h00, a};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_checks++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // Bridge model: samples the request half a cycle after it is stable and
    // drives the strobe so it is sampled on the second edge after acceptance.
    initial begin : bridge
        logic       p0v, p1v;
        logic [8:0] p0a, p1a;
        p0v = 1'b0; p1v = 1'b0; p0a = 9'd0; p1a = 9'd0;
        rsp_valid = 1'b0; rsp_data = 32'h0;
        forever begin
            @(negedge slave_clk);
            #1;
            if (!slave_reset_n) begin
                p0v = 1'b0; p1v = 1'b0; rsp_valid = 1'b0;
            end else begin
                rsp_valid = p1v;
                rsp_data  = rd_data(p1a);
                p1v = p0v; p1a = p0a;
                p0v = avm_read && !avm_waitrequest;
                p0a = avm_address;
            end
        end
    end

    task automatic check_reset_values();
        check("rst_cmd_ready", cmd_ready, 1);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_avm_read", avm_read, 0);
        check("rst_avm_address", avm_address, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_last", out_last, 0);
        check("rst_err", err_unexpected, 0);
    endtask

    task automatic run_burst(input logic [8:0] a, input logic [9:0] n, input int stall_idx,
                             input int ready_delay, input int bp_reads);
        int acc, pops, dones, cyc, stall_left, ph;
        logic [8:0] ea, pa;
        acc = 0; pops = 0; dones = 0; cyc = 0; stall_left = 5; ph = 0; ea = a; pa = a;
        @(negedge slave_clk);
        cmd_valid = 1'b1; cmd_address = a; cmd_count = n; out_ready = (ready_delay == 0);
        @(negedge slave_clk);
        cmd_valid = 1'b0;
        check("first_busy", busy, 1);
        check("first_cmd_ready", cmd_ready, 0);
        check("first_read", avm_read, 1);
        check("first_addr", avm_address, a);
        while (ph < 3 && cyc < 3000) begin
            if (ph == 1) begin
                check("done_pulse", done, 1);
                ph = 2;
            end else if (ph == 2) begin
                check("done_width", done, 0);
                check("ready_back", cmd_ready, 1);
                ph = 3;
            end
            if (done) dones++;
            out_ready = (cyc >= ready_delay);
            if (bp_reads > 0 && cyc == ready_delay - 1) begin
                check("bp_reads", acc, bp_reads);
                check("bp_read_low", avm_read, 0);
            end
            avm_waitrequest = 1'b0;
            if (stall_left > 0 && stall_left < 5) check("hold_read", avm_read, 1);
            if (avm_read && acc == stall_idx && stall_left > 0) begin
                avm_waitrequest = 1'b1;
                check("hold_addr", avm_address, ea);
                stall_left--;
            end
            if (avm_read && !avm_waitrequest) begin
                check("acc_addr", avm_address, ea);
                check("native_addr", avm_nativeaddress, ea);
                ea = ea + 9'd1;
                acc++;
            end
            if (out_valid && out_ready) begin
                check("out_data", out_data, rd_data(pa));
                check("out_last", out_last, (pops == n - 1));
                pa = pa + 9'd1;
                pops++;
                if (pops == n) ph = 1;
            end
            cyc++;
            if (ph < 3) @(negedge slave_clk);
        end
        avm_waitrequest = 1'b0;
        check("burst_finished", ph, 3);
        check("reads", acc, n);
        check("pops", pops, n);
        check("dones", dones, 1);
    endtask

    initial begin : main
        int acc;
        slave_reset_n = 1'b0; cmd_valid = 1'b0; cmd_address = 9'd0; cmd_count = 10'd0;
        avm_waitrequest = 1'b0; avm_endofpacket = 1'b0; out_ready = 1'b0; stray_valid = 1'b0;
        repeat (3) @(negedge slave_clk);
        check_reset_values();
        check("byteenable", avm_byteenable, 4'hF);
        check("write_const", avm_write, 0);
        check("writedata_const", avm_writedata, 0);
        slave_reset_n = 1'b1;
        @(negedge slave_clk);

        run_burst(9'h010, 10'd4, -1, 0, 0);
        avm_endofpacket = 1'b1;
        run_burst(9'h1FE, 10'd4, -1, 0, 0);
        avm_endofpacket = 1'b0;
        run_burst(9'h080, 10'd6, 1, 0, 0);
        run_burst(9'h100, 10'd40, -1, 40, 16);

        // Zero-length command
        @(negedge slave_clk);
        cmd_valid = 1'b1; cmd_address = 9'h055; cmd_count = 10'd0;
        @(negedge slave_clk);
        cmd_valid = 1'b0;
        check("zero_done", done, 1);
        check("zero_no_read", avm_read, 0);
        @(negedge slave_clk);
        check("zero_done_off", done, 0);
        check("zero_idle", cmd_ready, 1);
        check("zero_no_read2", avm_read, 0);

        // Stray return while idle
        stray_valid = 1'b1;
        @(negedge slave_clk);
        stray_valid = 1'b0;
        check("stray_err", err_unexpected, 1);
        check("stray_dropped", out_valid, 0);
        repeat (3) @(negedge slave_clk);
        check("stray_sticky", err_unexpected, 1);

        // Reset after three of eight reads
        cmd_valid = 1'b1; cmd_address = 9'h020; cmd_count = 10'd8; out_ready = 1'b1;
        @(negedge slave_clk);
        cmd_valid = 1'b0;
        acc = 0;
        for (int c = 0; c < 50 && acc < 3; c++) begin
            if (avm_read && !avm_waitrequest) acc++;
            if (acc < 3) @(negedge slave_clk);
        end
        check("mid_reads", acc, 3);
        @(posedge slave_clk);
        #2;
        slave_reset_n = 1'b0;
        #1;
        check_reset_values();
        repeat (2) @(negedge slave_clk);
        slave_reset_n = 1'b1;
        repeat (4) @(negedge slave_clk);
        check("post_rst_err", err_unexpected, 0);
        check("post_rst_idle", cmd_ready, 1);
        run_burst(9'h030, 10'd3, -1, 0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
